// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, owner encoding and the
// request-to-state arbitration helper used both from idle and at owner release.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_M0    = 2'd1,
        S_M1    = 2'd2,
        S_ABORT = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    // prefer_m1 only matters on a tie; fixed priority passes 0 so video always wins.
    function automatic arb_state_t arbitrate(input logic m0_req, input logic m1_req,
                                             input logic prefer_m1);
        arb_state_t nxt;
        if (m0_req && m1_req) begin
            nxt = prefer_m1 ? S_M1 : S_M0;
        end else if (m0_req) begin
            nxt = S_M0;
        end else if (m1_req) begin
            nxt = S_M1;
        end else begin
            nxt = S_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Ack watchdog: counts owner cycles without an ack and pulses fire_o on the TIMEOUT-th one.
// An ack (or any clear) in the firing cycle suppresses the fire.
module wb_watchdog #(
    parameter int unsigned TW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic fire_o
);

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_MAX  = '1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign fire_o = en_i && !clr_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || fire_o) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_video_arbiter.sv
// Two-master Wishbone arbiter (m0 = video fetch, m1 = CPU) onto one memory slave, with an ack watchdog.
// Define WBARB_FAIR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module wb_video_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // m0: video fetch master
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [DW-1:0]     m0_dat_m_i,
    output logic [DW-1:0]     m0_dat_s_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    // m1: CPU master
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [DW-1:0]     m1_dat_m_i,
    output logic [DW-1:0]     m1_dat_s_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    // s: shared memory slave
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [DW-1:0]     s_dat_m_o,
    input  logic [DW-1:0]     s_dat_s_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    arb_state_t state_q, state_d;
    logic       timeout_q;
    logic [1:0] abort_own_q;
    logic       prefer_m1;
    logic       owner_active;
    logic       owner_release;
    logic       aborted_cyc;
    logic       wd_fire;
    logic       wd_clr;

    assign owner_active  = (state_q == S_M0) || (state_q == S_M1);
    assign owner_release = ((state_q == S_M0) && !m0_cyc_i) || ((state_q == S_M1) && !m1_cyc_i);
    assign aborted_cyc   = (abort_own_q == OWN_M0) ? m0_cyc_i : m1_cyc_i;

    // Clearing throughout idle/abort is equivalent to clearing on entry to an owner state,
    // and avoids feeding state_d back into the watchdog.
    assign wd_clr = s_ack_i || !owner_active || owner_release;

    wb_watchdog #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (wd_clr),
        .en_i   (owner_active),
        .fire_o (wd_fire)
    );

`ifdef WBARB_FAIR_EN
    logic [1:0] last_owner_q;

    assign prefer_m1 = (last_owner_q == OWN_M0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_owner_q <= OWN_M1;
        end else if (state_d == S_M0) begin
            last_owner_q <= OWN_M0;
        end else if (state_d == S_M1) begin
            last_owner_q <= OWN_M1;
        end
    end
`else
    assign prefer_m1 = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            timeout_q   <= 1'b0;
            abort_own_q <= OWN_NONE;
        end else begin
            state_q   <= state_d;
            timeout_q <= wd_fire;
            if (wd_fire) begin
                abort_own_q <= (state_q == S_M0) ? OWN_M0 : OWN_M1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = arbitrate(m0_cyc_i, m1_cyc_i, prefer_m1);
            S_M0: begin
                if (!m0_cyc_i) begin
                    state_d = arbitrate(m0_cyc_i, m1_cyc_i, prefer_m1);
                end else if (wd_fire) begin
                    state_d = S_ABORT;
                end
            end
            S_M1: begin
                if (!m1_cyc_i) begin
                    state_d = arbitrate(m0_cyc_i, m1_cyc_i, prefer_m1);
                end else if (wd_fire) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                if (!aborted_cyc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data fans out to both masters unqualified; only ack/err say who it is for.
    assign m0_dat_s_o = s_dat_s_i;
    assign m1_dat_s_o = s_dat_s_i;

    always_comb begin
        grant_o   = OWN_NONE;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_sel_o   = '0;
        s_dat_m_o = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        case (state_q)
            S_M0: begin
                grant_o   = OWN_M0;
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_adr_o   = m0_adr_i;
                s_sel_o   = m0_sel_i;
                s_dat_m_o = m0_dat_m_i;
                m0_ack_o  = s_ack_i;
            end
            S_M1: begin
                grant_o   = OWN_M1;
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_adr_o   = m1_adr_i;
                s_sel_o   = m1_sel_i;
                s_dat_m_o = m1_dat_m_i;
                m1_ack_o  = s_ack_i;
            end
            default: ;
        endcase
        timeout_o = timeout_q;
        m0_err_o  = timeout_q && (abort_own_q == OWN_M0);
        m1_err_o  = timeout_q && (abort_own_q == OWN_M1);
    end

endmodule
